// File: rtl/scope_capture.sv
// scope_capture: arm / level-trigger / capture buffer for a sampled stream.
// After arming, a rising crossing of `level` (or force_trig) starts a capture
// of 2^A_WIDTH `en`-qualified samples into internal RAM, trigger sample at
// address 0. A registered random-access read port exposes the buffer.
module scope_capture #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [D_WIDTH-1:0] din,
    input  logic               arm,
    input  logic               force_trig,
    input  logic [D_WIDTH-1:0] level,
    input  logic [A_WIDTH-1:0] rd_addr,
    output logic [D_WIDTH-1:0] rd_data,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int DEPTH = 1 << A_WIDTH;
    localparam logic [A_WIDTH-1:0] PTR_ZERO = {A_WIDTH{1'b0}};
    localparam logic [A_WIDTH-1:0] PTR_ONE  = {{(A_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [A_WIDTH-1:0] PTR_LAST = {A_WIDTH{1'b1}};

    state_t               state_q, state_d;
    logic [A_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic                 prev_valid_q, prev_valid_d;
    logic [D_WIDTH-1:0]   prev_q, prev_d;
    logic [D_WIDTH-1:0]   rd_data_q;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 wr_en_s;
    logic                 hit_s;
    logic [D_WIDTH-1:0]   mem_q [0:DEPTH-1];

    // Rising crossing needs a valid previous sample; force_trig bypasses the compare.
    assign hit_s = force_trig | (prev_valid_q & (prev_q < level) & (din >= level));

    // State and control registers; RAM is deliberately excluded from reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= PTR_ZERO;
            prev_valid_q <= 1'b0;
            prev_q       <= {D_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            prev_valid_q <= prev_valid_d;
            prev_q       <= prev_d;
        end
    end

    // Next-state logic: arming, trigger evaluation and capture progress.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        prev_valid_d = prev_valid_q;
        prev_d       = prev_q;
        wr_en_s      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // The arming sample is never evaluated and never loads prev.
                if (arm) begin
                    state_d      = ST_ARMED;
                    wr_ptr_d     = PTR_ZERO;
                    prev_valid_d = 1'b0;
                end else begin
                    state_d      = state_q;
                end
            end
            ST_ARMED: begin
                if (en) begin
                    prev_d       = din;
                    prev_valid_d = 1'b1;
                    if (hit_s) begin
                        // wr_ptr is zero here, so the trigger sample lands at address 0.
                        wr_en_s  = 1'b1;
                        wr_ptr_d = PTR_ONE;
                        state_d  = ST_CAPTURE;
                    end else begin
                        state_d  = ST_ARMED;
                    end
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                if (en) begin
                    wr_en_s  = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (wr_ptr_q == PTR_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status decode from the next state so the flags register alongside state_q.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            ST_ARMED:   busy_d = 1'b1;
            ST_CAPTURE: busy_d = 1'b1;
            ST_DONE:    done_d = 1'b1;
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // Registered status flags, glitch-free and cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Capture RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Registered read port: same-address write in the same cycle returns old data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= {D_WIDTH{1'b0}};
        end else begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_scope_capture.sv
// Scoreboard bench for scope_capture (A_WIDTH=4, D_WIDTH=8): directed scenarios
// plus random traffic, checked against a behavioural model of the capture rules.
module tb_scope_capture;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          arm = 1'b0;
    logic          force_trig = 1'b0;
    logic [DW-1:0] din = 8'h00;
    logic [DW-1:0] level = 8'h00;
    logic [AW-1:0] rd_addr = 4'h0;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;

    scope_capture #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .arm(arm),
        .force_trig(force_trig), .level(level), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rd;
        bit         rd_known;
        bit         busy;
        bit         done;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Behavioural reference: mode, samples stored so far, last seen sample.
    localparam int M_IDLE = 0, M_ARMED = 1, M_CAP = 2, M_DONE = 3;
    int         m_mode  = M_IDLE;
    int         m_count = 0;
    bit         m_pv    = 1'b0;
    logic [7:0] m_prev  = 8'h00;
    logic [7:0] m_mem   [DEPTH];
    bit         m_known [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_count = 0;
        m_pv    = 1'b0;
        m_prev  = 8'h00;
    endtask

    task automatic model_step(input bit e, input bit a, input bit f,
                              input logic [7:0] d, input logic [7:0] lv);
        case (m_mode)
            M_IDLE, M_DONE: begin
                if (a) begin
                    m_mode  = M_ARMED;
                    m_count = 0;
                    m_pv    = 1'b0;
                end
            end
            M_ARMED: begin
                if (e) begin
                    bit hit;
                    hit    = f || (m_pv && (m_prev < lv) && (d >= lv));
                    m_prev = d;
                    m_pv   = 1'b1;
                    if (hit) begin
                        m_mem[0]   = d;
                        m_known[0] = 1'b1;
                        m_count    = 1;
                        m_mode     = M_CAP;
                    end
                end
            end
            M_CAP: begin
                if (e) begin
                    m_mem[m_count]   = d;
                    m_known[m_count] = 1'b1;
                    m_count++;
                    if (m_count == DEPTH) m_mode = M_DONE;
                end
            end
            default: ;
        endcase
    endtask

    // Drive one cycle of stimulus and queue the response expected after the edge.
    task automatic cyc(input bit e, input bit a, input bit f,
                       input logic [7:0] d, input logic [7:0] lv, input logic [3:0] ra);
        exp_t x;
        @(negedge clk);
        en = e; arm = a; force_trig = f; din = d; level = lv; rd_addr = ra;
        x.rd       = m_mem[ra];
        x.rd_known = m_known[ra];
        model_step(e, a, f, d, lv);
        x.busy = (m_mode == M_ARMED) || (m_mode == M_CAP);
        x.done = (m_mode == M_DONE);
        exp_q.push_back(x);
    endtask

    function automatic logic [7:0] r8();
        return 8'($urandom);
    endfunction

    function automatic logic [3:0] r4();
        return 4'($urandom);
    endfunction

    task automatic read_all(input logic [7:0] lv);
        for (int a = 0; a < DEPTH; a++) cyc(1'b0, 1'b0, 1'b0, r8(), lv, 4'(a));
    endtask

    // Monitor: one expectation per clock, compared just after the edge.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("busy", 32'(busy), 32'(x.busy));
            chk("done", 32'(done), 32'(x.done));
            if (x.rd_known) chk("rd_data", 32'(rd_data), 32'(x.rd));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        model_reset();

        // Reset state while held in reset.
        #3;
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_rd",   32'(rd_data), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) cyc(1'b1, 1'b0, 1'b0, r8(), 8'h80, r4());

        // Level trigger on a ramp crossing 0x80.
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h80, r4());
        for (int i = 0; i < 18; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h70 + 8 * i), 8'h80, r4());
        read_all(8'h80);

        // Constant above level never triggers; a real crossing does.
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h80, r4());
        repeat (20) cyc(1'b1, 1'b0, 1'b0, 8'h90, 8'h80, r4());
        cyc(1'b1, 1'b0, 1'b0, 8'h10, 8'h80, r4());
        cyc(1'b1, 1'b0, 1'b0, 8'h90, 8'h80, r4());
        repeat (17) cyc(1'b1, 1'b0, 1'b0, r8(), 8'h80, r4());

        // Forced trigger with a gapped stream; arm coincides with en in DONE.
        cyc(1'b1, 1'b1, 1'b0, 8'hEE, 8'h80, r4());
        cyc(1'b1, 1'b0, 1'b1, 8'h05, 8'h80, r4());
        v = 8'h06;
        for (int k = 0; k < 32; k++) begin
            if (k % 2 == 0) begin
                cyc(1'b1, 1'b0, 1'b0, v, 8'h80, r4());
                v = v + 8'h01;
            end else begin
                cyc(1'b0, 1'b0, 1'b0, r8(), 8'h80, r4());
            end
        end
        read_all(8'h80);

        // Arm ignored mid-capture and on the final write; index 3 gets 0x11.
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, r4());
        cyc(1'b1, 1'b0, 1'b1, 8'h40, 8'hFF, r4());
        for (int i = 1; i < DEPTH; i++)
            cyc(1'b1, (i == 5 || i == 15), 1'b0, (i == 3) ? 8'h11 : r8(), 8'hFF, r4());
        repeat (3) cyc(1'b0, 1'b0, 1'b0, r8(), 8'hFF, r4());

        // Re-arm from DONE; old data readable; read-during-write at address 3.
        cyc(1'b1, 1'b1, 1'b0, r8(), 8'hFF, 4'd3);
        cyc(1'b0, 1'b0, 1'b0, r8(), 8'hFF, 4'd3);
        cyc(1'b1, 1'b0, 1'b1, 8'h41, 8'hFF, 4'd3);
        for (int i = 1; i < DEPTH; i++)
            cyc(1'b1, 1'b0, 1'b0, (i == 3) ? 8'hAA : r8(), 8'hFF, 4'd3);
        cyc(1'b0, 1'b0, 1'b0, r8(), 8'hFF, 4'd3);

        // Asynchronous reset mid-capture, then stay idle until armed.
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h80, r4());
        cyc(1'b1, 1'b0, 1'b1, 8'h22, 8'h80, r4());
        repeat (5) cyc(1'b1, 1'b0, 1'b0, r8(), 8'h80, r4());
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_done", 32'(done), 32'h0);
        chk("async_rd",   32'(rd_data), 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) cyc(1'(i % 2), 1'b0, 1'(i % 3 == 0), r8(), 8'h00, r4());

        // Random traffic.
        begin
            logic [7:0] lv;
            lv = r8();
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(0, 49) == 0) lv = r8();
                cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 15) == 0), r8(), lv, r4());
            end
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
